// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: one digit lit at a time with a blanking gap
// between digits, snapshotting the digit codes once per frame so a number never tears.
module seg_scan_driver #(
    parameter int NDIG     = 4,
    parameter int DWELL    = 50000,
    parameter int BLANK    = 1000,
    parameter int LZ_BLANK = 1
) (
    input  logic              C,
    input  logic              rst,
    input  logic [4*NDIG-1:0] bcd_in,
    input  logic [NDIG-1:0]   dp_in,
    output logic [7:0]        out,
    output logic [NDIG-1:0]   digit
);

    localparam int TMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK > 0) ? (BLANK - 1) : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

    localparam logic [0:0] ST_GAP  = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [4*NDIG-1:0] snap_bcd_q, snap_bcd_d;
    logic [NDIG-1:0]   snap_dp_q, snap_dp_d;
    logic [7:0]        out_q, out_d;
    logic [NDIG-1:0]   digit_q, digit_d;

    logic              frame_start_s;
    logic [4*NDIG-1:0] src_bcd_s;
    logic [NDIG-1:0]   src_dp_s;
    logic [7:0]        seg_s;

    // Active-low hex patterns with the dp bit (bit 7) left dark.
    function automatic logic [7:0] seg_decode(input logic [3:0] code);
        logic [7:0] s;
        case (code)
            4'h0:    s = 8'hC0;
            4'h1:    s = 8'hF9;
            4'h2:    s = 8'hA4;
            4'h3:    s = 8'hB0;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h92;
            4'h6:    s = 8'h82;
            4'h7:    s = 8'hF8;
            4'h8:    s = 8'h80;
            4'h9:    s = 8'h90;
            4'hA:    s = 8'h88;
            4'hB:    s = 8'h83;
            4'hC:    s = 8'hC6;
            4'hD:    s = 8'hA1;
            4'hE:    s = 8'h86;
            4'hF:    s = 8'h8E;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // A digit is a leading zero when it and every digit above it are zero.
    function automatic logic lz_suppress(input logic [4*NDIG-1:0] src, input logic [IW-1:0] idx);
        logic nz;
        nz = 1'b0;
        for (int j = 0; j < NDIG; j++) begin
            nz = nz | ((j >= int'(idx)) && (src[4*j +: 4] != 4'h0));
        end
        return (LZ_BLANK != 0) && (idx != '0) && !nz;
    endfunction

    // Scan sequencing plus next output values, so outputs change on the state edge.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        timer_d    = timer_q + TW'(1);
        snap_bcd_d = snap_bcd_q;
        snap_dp_d  = snap_dp_q;
        case (state_q)
            ST_GAP: begin
                if ((BLANK == 0) || (timer_q == BLANK_LAST)) begin
                    state_d = ST_SHOW;
                    timer_d = '0;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_SHOW: begin
                if (timer_q == DWELL_LAST) begin
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                    timer_d = '0;
                    state_d = (BLANK == 0) ? ST_SHOW : ST_GAP;
                end else begin
                    state_d = ST_SHOW;
                end
            end
            default: begin
                state_d = ST_GAP;
                idx_d   = '0;
                timer_d = '0;
            end
        endcase

        // The frame starts on any edge that begins a fresh SHOW slot for digit 0.
        frame_start_s = (state_d == ST_SHOW) && (idx_d == '0) &&
                        ((state_q == ST_GAP) || (timer_q == DWELL_LAST));
        if (frame_start_s) begin
            snap_bcd_d = bcd_in;
            snap_dp_d  = dp_in;
            src_bcd_s  = bcd_in;
            src_dp_s   = dp_in;
        end else begin
            src_bcd_s  = snap_bcd_q;
            src_dp_s   = snap_dp_q;
        end

        if (state_d == ST_SHOW) begin
            seg_s   = lz_suppress(src_bcd_s, idx_d) ? 8'hFF : seg_decode(src_bcd_s[{idx_d, 2'b00} +: 4]);
            out_d   = {~src_dp_s[idx_d], seg_s[6:0]};
            digit_d = ~(NDIG'(1) << idx_d);
        end else begin
            seg_s   = 8'hFF;
            out_d   = 8'hFF;
            digit_d = '1;
        end
    end

    // State, snapshot and registered outputs.
    always_ff @(posedge C or posedge rst) begin
        if (rst) begin
            state_q    <= ST_GAP;
            idx_q      <= '0;
            timer_q    <= '0;
            snap_bcd_q <= '0;
            snap_dp_q  <= '0;
            out_q      <= 8'hFF;
            digit_q    <= '1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            snap_bcd_q <= snap_bcd_d;
            snap_dp_q  <= snap_dp_d;
            out_q      <= out_d;
            digit_q    <= digit_d;
        end
    end

    assign out   = out_q;
    assign digit = digit_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a BLANK=2 and a BLANK=0 instance checked by vector
// table, hand sequences, and a cycle-position reference model under random input.
module tb_seg_scan_driver;

    logic        C;
    logic        rst;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [7:0]  out_a, out_b;
    logic [3:0]  digit_a, digit_b;

    int checks;
    int failures;

    localparam logic [7:0] SEG_TAB [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg_scan_driver #(.NDIG(4), .DWELL(4), .BLANK(2), .LZ_BLANK(1)) dut_a (
        .C(C), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .out(out_a), .digit(digit_a));

    seg_scan_driver #(.NDIG(4), .DWELL(4), .BLANK(0), .LZ_BLANK(1)) dut_b (
        .C(C), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .out(out_b), .digit(digit_b));

    initial C = 1'b0;
    always #5 C = ~C;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dp;
        int          slot;
        logic [7:0]  exp_out;
        logic [3:0]  exp_digit;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge C);
    endtask

    // Leaves the bench at the negedge where reset has just released (cycle 0).
    task automatic apply_reset(input logic [15:0] b, input logic [3:0] d);
        @(negedge C);
        rst    = 1'b1;
        bcd_in = b;
        dp_in  = d;
        #1;
        chk("reset_out_a", 32'(out_a), 32'hFF);
        chk("reset_digit_a", 32'(digit_a), 32'hF);
        chk("reset_digit_b", 32'(digit_b), 32'hF);
        @(negedge C);
        @(negedge C);
        rst = 1'b0;
    endtask

    function automatic logic [7:0] exp_seg(input logic [15:0] snap, input logic [3:0] dpv, input int slot);
        logic [7:0]  s;
        logic [15:0] hi;
        logic [3:0]  code;
        hi   = snap >> (4 * slot);
        code = hi[3:0];
        s    = (slot > 0 && hi == 16'h0) ? 8'hFF : SEG_TAB[code];
        if (dpv[slot]) s[7] = 1'b0;
        return s;
    endfunction

    initial begin
        logic [15:0] snap_a, snap_b;
        logic [3:0]  sdp_a, sdp_b;
        logic [7:0]  eo;
        logic [3:0]  ed;
        int          p;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bcd_in   = 16'h0;
        dp_in    = 4'h0;

        vecs[0]  = '{16'h1234, 4'b0000, 0, 8'h99, 4'b1110};
        vecs[1]  = '{16'h1234, 4'b0000, 1, 8'hB0, 4'b1101};
        vecs[2]  = '{16'h1234, 4'b0000, 3, 8'hF9, 4'b0111};
        vecs[3]  = '{16'h0007, 4'b0000, 0, 8'hF8, 4'b1110};
        vecs[4]  = '{16'h0007, 4'b0000, 1, 8'hFF, 4'b1101};
        vecs[5]  = '{16'h0007, 4'b0000, 3, 8'hFF, 4'b0111};
        vecs[6]  = '{16'h0000, 4'b0000, 0, 8'hC0, 4'b1110};
        vecs[7]  = '{16'h0900, 4'b0100, 2, 8'h10, 4'b1011};
        vecs[8]  = '{16'h0900, 4'b0100, 1, 8'hC0, 4'b1101};
        vecs[9]  = '{16'h0900, 4'b0100, 3, 8'hFF, 4'b0111};
        vecs[10] = '{16'h0000, 4'b1000, 3, 8'h7F, 4'b0111};
        vecs[11] = '{16'hABEF, 4'b0001, 0, 8'h0E, 4'b1110};

        // Table: each digit slot is lit from cycle 2+6*slot through 5+6*slot.
        for (int i = 0; i < 12; i++) begin
            apply_reset(vecs[i].bcd, vecs[i].dp);
            run(1);
            chk("gap_digit", 32'(digit_a), 32'hF);
            run(1 + 6 * vecs[i].slot);
            chk("vec_out_first", 32'(out_a), 32'(vecs[i].exp_out));
            chk("vec_digit_first", 32'(digit_a), 32'(vecs[i].exp_digit));
            run(3);
            chk("vec_out_last", 32'(out_a), 32'(vecs[i].exp_out));
            chk("vec_digit_last", 32'(digit_a), 32'(vecs[i].exp_digit));
            run(1);
            chk("vec_gap_out", 32'(out_a), 32'hFF);
            chk("vec_gap_digit", 32'(digit_a), 32'hF);
        end

        // Input change mid-frame stays hidden until the next frame.
        apply_reset(16'h1234, 4'h0);
        run(15);
        bcd_in = 16'h5678;
        run(1);
        chk("tear_d2_out", 32'(out_a), 32'hA4);
        run(4);
        chk("tear_d3_out", 32'(out_a), 32'hF9);
        chk("tear_d3_digit", 32'(digit_a), 32'h7);
        run(6);
        chk("next_d0_out", 32'(out_a), 32'h80);
        run(6);
        chk("next_d1_out", 32'(out_a), 32'hF8);
        run(12);
        chk("next_d3_out", 32'(out_a), 32'h92);

        // Asynchronous reset in the middle of a SHOW slot.
        apply_reset(16'h1234, 4'h0);
        run(3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out", 32'(out_a), 32'hFF);
        chk("async_rst_digit", 32'(digit_a), 32'hF);
        chk("async_rst_digit_b", 32'(digit_b), 32'hF);
        @(negedge C);
        rst = 1'b0;
        run(1);
        chk("restart_gap", 32'(digit_a), 32'hF);
        run(1);
        chk("restart_d0_out", 32'(out_a), 32'h99);
        chk("restart_d0_digit", 32'(digit_a), 32'hE);

        // Random inputs against a frame-position model for both instances.
        apply_reset(16'(($urandom & 32'h1) != 0 ? $urandom : ($urandom & 32'hFF)), 4'($urandom));
        snap_a = 16'h0; sdp_a = 4'h0;
        snap_b = 16'h0; sdp_b = 4'h0;
        for (int c = 0; c < 600; c++) begin
            if (c > 0) @(negedge C);
            p = c % 24;
            if (p == 2) begin
                snap_a = bcd_in;
                sdp_a  = dp_in;
            end
            if (c >= 1 && ((c - 1) % 16) == 0) begin
                snap_b = bcd_in;
                sdp_b  = dp_in;
            end
            if ((p % 6) < 2) begin
                eo = 8'hFF;
                ed = 4'hF;
            end else begin
                eo = exp_seg(snap_a, sdp_a, p / 6);
                ed = ~(4'b0001 << (p / 6));
            end
            chk("rand_out_a", 32'(out_a), 32'(eo));
            chk("rand_digit_a", 32'(digit_a), 32'(ed));
            if (c == 0) begin
                eo = 8'hFF;
                ed = 4'hF;
            end else begin
                eo = exp_seg(snap_b, sdp_b, ((c - 1) % 16) / 4);
                ed = ~(4'b0001 << (((c - 1) % 16) / 4));
            end
            chk("rand_out_b", 32'(out_b), 32'(eo));
            chk("rand_digit_b", 32'(digit_b), 32'(ed));
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0:       bcd_in = 16'($urandom);
                    1:       bcd_in = 16'($urandom & 32'h00FF);
                    default: bcd_in = 16'($urandom & 32'h000F);
                endcase
                dp_in = 4'($urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
